acionador_irrigacao: RTL and testbench
======================================

Name: acionador_irrigacao

Overview:
- Actuator sequencer on the far side of the irrigation decision logic; consumes the sprinkler (Vs) and drip (Bs) requests and drives the physical valves and the shared pump.
- Enforces valve-before-pump and pump-before-valve ordering, minimum and maximum run times, and a water-level interlock.
- Timing is counted in `tick` pulses, a 1-cycle enable from a shared prescaler, not in clock cycles.

Parameters:
- VALVE_DLY, 2, ticks between valve open and pump on
- MIN_RUN, 5, minimum pump-on ticks before a request drop is honoured
- MAX_RUN, 60, pump-on tick limit; reaching it forces shutdown and a lockout
- STOP_DLY, 2, ticks between pump off and valve close
- CW, 8, timer counter width; must hold max(VALVE_DLY, MIN_RUN, MAX_RUN, STOP_DLY)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  timebase enable, one clk cycle wide
- Vs  in  1  sprinkler request, level-sensitive
- Bs  in  1  drip request, level-sensitive
- L  in  1  reservoir level sensor; 1 means water is available
- valv_asp  out  1  sprinkler valve drive
- valv_got  out  1  drip valve drive
- bomba  out  1  pump drive
- ocupado  out  1  high in every state except OCIOSO
- alarme  out  1  high in FALHA and TRAVA

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `rst`.
- Reset has priority over every other input. Reset values: all outputs 0, state OCIOSO, timer 0, selected channel cleared.
- Reset mid-cycle (pump on) forces all outputs to 0 on the next edge. No ordered shutdown is performed.
- All outputs are registered and decoded from the state and the latched channel.
- Timer rule: cleared on every state entry; increments only when `tick`=1; compared with >=.
- Channel selection happens in OCIOSO only. Vs has priority over Bs. The channel is latched, and an input change while running does not switch channels.
- OCIOSO:
  - If L=1 and (Vs|Bs): latch channel, go to ABRE.
  - If Vs|Bs with L=0: set alarme, go to FALHA.
- ABRE: open the selected valve, pump off.
  - Timer >= VALVE_DLY: go to RODA.
  - Request dropped: go to FECHA, no pump start.
- RODA: valve on, bomba=1.
  - Leave for PARA when the request is dropped and timer >= MIN_RUN.
  - Leave for PARA unconditionally when timer >= MAX_RUN, and set a lockout flag.
- PARA: bomba=0, valve stays open.
  - Timer >= STOP_DLY: go to FECHA.
- FECHA: valves closed, one clk cycle.
  - Lockout flag set: go to TRAVA.
  - Otherwise: go to OCIOSO.
- L=0 in ABRE, RODA or PARA:
  - Same edge: bomba=0, both valves=0, go to FALHA.
  - The dry-run interlock overrides MIN_RUN.
- FALHA: alarme=1, all drives 0. Return to OCIOSO when L=1 and Vs=Bs=0.
- TRAVA: alarme=1, all drives 0. Return to OCIOSO only when Vs=Bs=0 for one full tick.
- Invariants:
  - bomba=1 implies exactly one valve is 1.
  - valv_asp and valv_got are never both 1.
- Simultaneous events in the same cycle resolve by priority: rst > L=0 > MAX_RUN > request drop.

Decomposition:
- Shared package `irrigacao_pkg`:
  - state enum: OCIOSO, ABRE, RODA, PARA, FECHA, FALHA, TRAVA
  - channel constant: CH_ASP=0, CH_GOT=1
- Sub-module `temporizador_tick`: CW-bit counter with inputs clr, tick and a terminal-count compare. It is instantiated once and shared across states.

Test Plan:
- Vs=1, L=1, tick every 4 clk:
  - valv_asp=1 one edge after request.
  - bomba=1 after 2 ticks.
  - Drop Vs after 10 ticks: bomba=0, then valv_asp=0 2 ticks later, back to OCIOSO.
- Bs=1, held 1 tick into RODA, then dropped: bomba stays 1 until MIN_RUN=5 ticks, then PARA/FECHA on valv_got.
- Vs=1 and Bs=1 together: only valv_asp ever asserts. Deassert Vs mid-RODA with Bs still high: channel stays asp.
- L falls to 0 in RODA:
  - Next edge: bomba=0, valves=0, alarme=1.
  - Raise L while Vs held: stays FALHA.
  - Drop Vs: OCIOSO, alarme=0.
- Hold Vs for 70 ticks: bomba=0 at tick 60, then FECHA, then TRAVA with alarme=1. Stays locked while Vs=1; releases one tick after Vs=0.
- Assert rst while bomba=1: all outputs 0 on the next edge. Request still high after rst release: a fresh sequence starts in ABRE.

Source files
------------

// File: rtl/irrigacao_pkg.sv
// rtl/irrigacao_pkg.sv - shared states, channel codes and output decode helpers for the irrigation actuator
package irrigacao_pkg;

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        ABRE   = 3'd1,
        RODA   = 3'd2,
        PARA   = 3'd3,
        FECHA  = 3'd4,
        FALHA  = 3'd5,
        TRAVA  = 3'd6
    } estado_t;

    localparam logic CH_ASP = 1'b0;
    localparam logic CH_GOT = 1'b1;

    // Selected valve is driven while opening, running and in the post-pump drain
    function automatic logic valvula_aberta(input estado_t e);
        return (e == ABRE) || (e == RODA) || (e == PARA);
    endfunction

    function automatic logic em_alarme(input estado_t e);
        return (e == FALHA) || (e == TRAVA);
    endfunction

endpackage

// File: rtl/acionador_irrigacao_temporizador.sv
// rtl/acionador_irrigacao_temporizador.sv - tick-counting timer with clear and terminal-count compare
module temporizador_tick #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_tick,
    input  logic [CW-1:0] i_lim,
    output logic [CW-1:0] o_count,
    output logic          o_fim
);

    logic [CW-1:0] r_count;

    // Count ticks since the last clear; saturate so idle states never wrap
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_tick && (r_count != {CW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_fim   = (r_count >= i_lim);

endmodule

// File: rtl/acionador_irrigacao.sv
// rtl/acionador_irrigacao.sv - valve/pump sequencer with run-time limits and water-level interlock
module acionador_irrigacao
    import irrigacao_pkg::*;
#(
    parameter int VALVE_DLY = 2,
    parameter int MIN_RUN   = 5,
    parameter int MAX_RUN   = 60,
    parameter int STOP_DLY  = 2,
    parameter int CW        = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic Vs,
    input  logic Bs,
    input  logic L,
    output logic valv_asp,
    output logic valv_got,
    output logic bomba,
    output logic ocupado,
    output logic alarme
);

    estado_t       r_estado;
    estado_t       w_prox;
    logic          r_ch;
    logic          w_ch;
    logic          r_trava;
    logic          w_trava;
    logic          w_clr;
    logic [CW-1:0] w_lim;
    logic [CW-1:0] w_count;
    logic          w_fim;
    logic          w_req;
    logic          w_algum;

    // Only the latched channel's request keeps a cycle alive
    assign w_req   = (r_ch == CH_GOT) ? Bs : Vs;
    assign w_algum = Vs | Bs;

    temporizador_tick #(.CW(CW)) u_temporizador (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_tick  (tick),
        .i_lim   (w_lim),
        .o_count (w_count),
        .o_fim   (w_fim)
    );

    // State, latched channel and lockout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_ch     <= CH_ASP;
            r_trava  <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_ch     <= w_ch;
            r_trava  <= w_trava;
        end
    end

    // Next-state decode; dry-run interlock checked before any timer decision
    always_comb begin
        w_prox  = r_estado;
        w_ch    = r_ch;
        w_trava = r_trava;
        w_lim   = CW'(VALVE_DLY);
        case (r_estado)
            OCIOSO: begin
                w_trava = 1'b0;
                if (w_algum) begin
                    if (L) begin
                        w_ch   = Vs ? CH_ASP : CH_GOT;
                        w_prox = ABRE;
                    end else begin
                        w_prox = FALHA;
                    end
                end
            end
            ABRE: begin
                w_lim = CW'(VALVE_DLY);
                if (!L)         w_prox = FALHA;
                else if (!w_req) w_prox = FECHA;
                else if (w_fim)  w_prox = RODA;
            end
            RODA: begin
                w_lim = CW'(MAX_RUN);
                if (!L) begin
                    w_prox = FALHA;
                end else if (w_fim) begin
                    w_prox  = PARA;
                    w_trava = 1'b1;
                end else if (!w_req && (w_count >= CW'(MIN_RUN))) begin
                    w_prox = PARA;
                end
            end
            PARA: begin
                w_lim = CW'(STOP_DLY);
                if (!L)        w_prox = FALHA;
                else if (w_fim) w_prox = FECHA;
            end
            FECHA:   w_prox = r_trava ? TRAVA : OCIOSO;
            FALHA:   if (L && !w_algum) w_prox = OCIOSO;
            TRAVA: begin
                w_lim = CW'(1);
                if (!w_algum && w_fim) w_prox = OCIOSO;
            end
            default: w_prox = OCIOSO;
        endcase
        // Any request while locked restarts the quiet-tick wait
        w_clr = (w_prox != r_estado) || ((r_estado == TRAVA) && w_algum);
    end

    // Registered drives decoded from the upcoming state and channel
    always_ff @(posedge clk) begin
        if (rst) begin
            valv_asp <= 1'b0;
            valv_got <= 1'b0;
            bomba    <= 1'b0;
            ocupado  <= 1'b0;
            alarme   <= 1'b0;
        end else begin
            valv_asp <= valvula_aberta(w_prox) && (w_ch == CH_ASP);
            valv_got <= valvula_aberta(w_prox) && (w_ch == CH_GOT);
            bomba    <= (w_prox == RODA);
            ocupado  <= (w_prox != OCIOSO);
            alarme   <= em_alarme(w_prox);
        end
    end

endmodule

// File: tb/tb_acionador_irrigacao.sv
// tb/tb_acionador_irrigacao.sv - scoreboard bench for the irrigation actuator
module tb_acionador_irrigacao;

    localparam int VALVE_DLY = 2;
    localparam int MIN_RUN   = 5;
    localparam int MAX_RUN   = 60;
    localparam int STOP_DLY  = 2;

    localparam int P_IDLE  = 0;
    localparam int P_OPEN  = 1;
    localparam int P_RUN   = 2;
    localparam int P_STOP  = 3;
    localparam int P_CLOSE = 4;
    localparam int P_FAULT = 5;
    localparam int P_LOCK  = 6;

    logic clk = 1'b0;
    logic rst, tick, Vs, Bs, L;
    logic valv_asp, valv_got, bomba, ocupado, alarme;

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] exp_q[$];
    bit started = 1'b0;
    int cyc = 0;
    int tick_per = 4;

    logic sr, sv, sb, sl;

    int m_ph  = P_IDLE;
    int m_t   = 0;
    bit m_ch  = 1'b0;
    bit m_lk  = 1'b0;

    always #5 clk = ~clk;

    acionador_irrigacao #(
        .VALVE_DLY (VALVE_DLY),
        .MIN_RUN   (MIN_RUN),
        .MAX_RUN   (MAX_RUN),
        .STOP_DLY  (STOP_DLY),
        .CW        (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .Vs       (Vs),
        .Bs       (Bs),
        .L        (L),
        .valv_asp (valv_asp),
        .valv_got (valv_got),
        .bomba    (bomba),
        .ocupado  (ocupado),
        .alarme   (alarme)
    );

    task automatic model_step(input logic r, input logic t, input logic vs,
                              input logic bs, input logic l, output logic [4:0] e);
        int np;
        bit req, any, valve;
        if (r) begin
            m_ph = P_IDLE; m_t = 0; m_ch = 1'b0; m_lk = 1'b0;
        end else begin
            any = vs | bs;
            req = m_ch ? bs : vs;
            np  = m_ph;
            case (m_ph)
                P_IDLE: begin
                    m_lk = 1'b0;
                    if (any) begin
                        if (l) begin m_ch = !vs; np = P_OPEN; end
                        else np = P_FAULT;
                    end
                end
                P_OPEN:  if (!l) np = P_FAULT; else if (!req) np = P_CLOSE;
                         else if (m_t >= VALVE_DLY) np = P_RUN;
                P_RUN: begin
                    if (!l) np = P_FAULT;
                    else if (m_t >= MAX_RUN) begin np = P_STOP; m_lk = 1'b1; end
                    else if (!req && m_t >= MIN_RUN) np = P_STOP;
                end
                P_STOP:  if (!l) np = P_FAULT; else if (m_t >= STOP_DLY) np = P_CLOSE;
                P_CLOSE: np = m_lk ? P_LOCK : P_IDLE;
                P_FAULT: if (l && !any) np = P_IDLE;
                P_LOCK:  if (!any && m_t >= 1) np = P_IDLE;
                default: np = P_IDLE;
            endcase
            if (np != m_ph || (m_ph == P_LOCK && any)) m_t = 0;
            else if (t) m_t++;
            m_ph = np;
        end
        valve = (m_ph == P_OPEN) || (m_ph == P_RUN) || (m_ph == P_STOP);
        e = {valve && !m_ch, valve && m_ch, m_ph == P_RUN, m_ph != P_IDLE,
             (m_ph == P_FAULT) || (m_ph == P_LOCK)};
    endtask

    task automatic step();
        logic [4:0] e;
        @(negedge clk);
        cyc++;
        tick = ((cyc % tick_per) == 0);
        rst = sr; Vs = sv; Bs = sb; L = sl;
        model_step(rst, tick, Vs, Bs, L, e);
        exp_q.push_back(e);
        started = 1'b1;
    endtask

    task automatic run_cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            step();
            if (tick) seen++;
        end
    endtask

    // Monitor: compare every registered output sample against the queued expectation
    always @(posedge clk) begin
        logic [4:0] got, e;
        #1;
        got = {valv_asp, valv_got, bomba, ocupado, alarme};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL outputs cyc=%0d {asp,got,bomba,ocupado,alarme} got=%b exp=%b", cyc, got, e);
            end
            n_tests++;
            if ((valv_asp && valv_got) || (bomba && !(valv_asp ^ valv_got))) begin
                n_fail++;
                $display("FAIL invariant cyc=%0d asp=%b got=%b bomba=%b required one valve with pump, never both",
                         cyc, valv_asp, valv_got, bomba);
            end
        end else if (started) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard cyc=%0d got=%b exp=<none>", cyc, got);
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; Vs = 1'b0; Bs = 1'b0; L = 1'b1;
        sr = 1'b1; sv = 1'b0; sb = 1'b0; sl = 1'b1;
        run_cyc(2);
        sr = 1'b0;
        run_cyc(3);

        // sprinkler cycle, drop after ~10 run ticks
        sv = 1'b1; run_ticks(13); sv = 1'b0; run_ticks(6);
        // drip dropped early in RODA: MIN_RUN holds pump
        sb = 1'b1; run_ticks(3); sb = 1'b0; run_ticks(10);
        // both requested: sprinkler wins and stays latched
        sv = 1'b1; sb = 1'b1; run_ticks(5); sv = 1'b0; run_ticks(8); sb = 1'b0; run_ticks(6);
        // dry-run interlock in RODA
        sv = 1'b1; run_ticks(5); sl = 1'b0; run_cyc(3); sl = 1'b1; run_cyc(6); sv = 1'b0; run_cyc(4);
        // MAX_RUN lockout
        sv = 1'b1; run_ticks(70); sv = 1'b0; run_ticks(3);
        // reset while pumping, request held across release
        sv = 1'b1; run_ticks(5); sr = 1'b1; run_cyc(1); sr = 1'b0; run_ticks(4); sv = 1'b0; run_ticks(6);

        // randomized episodes
        for (int ep = 0; ep < 60; ep++) begin
            tick_per = $urandom_range(1, 5);
            sv = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            sl = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) begin
                sr = 1'b1; run_cyc(1); sr = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) run_ticks($urandom_range(55, 70));
            else run_ticks($urandom_range(0, 12));
        end
        sv = 1'b0; sb = 1'b0; sl = 1'b1;
        run_ticks(8);

        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
